// File: rtl/mux_fifo_seg_gen.sv
// mux_fifo_seg_gen: turns one transfer command into aligned
// segment beats for the unit-packing mux FIFO source port.
module mux_fifo_seg_gen #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_UNIT       = 8,
    parameter int USER_INFO_WIDTH = 8,
    parameter int LEN_WIDTH       = 16,
    localparam int UNITS      = DATA_WIDTH / DATA_UNIT,
    localparam int OFST_WIDTH = $clog2(UNITS),
    localparam int PTR_WIDTH  = OFST_WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [OFST_WIDTH-1:0]      cmd_src_ofst,
    input  logic [OFST_WIDTH-1:0]      cmd_dst_ofst,
    input  logic [LEN_WIDTH-1:0]       cmd_len,
    input  logic                       cmd_last,
    input  logic [USER_INFO_WIDTH-1:0] cmd_user_info,
    input  logic [DATA_WIDTH-1:0]      rd_data,
    input  logic                       rd_valid,
    output logic                       rd_ready,
    output logic [DATA_WIDTH-1:0]      seg_data,
    output logic                       seg_valid,
    input  logic                       seg_ready,
    output logic                       seg_bgin,
    output logic                       seg_done,
    output logic                       seg_last,
    output logic [PTR_WIDTH-1:0]       seg_unit_num,
    output logic [OFST_WIDTH-1:0]      seg_offset,
    output logic [OFST_WIDTH-1:0]      seg_initial_offset,
    output logic [USER_INFO_WIDTH-1:0] seg_user_info,
    output logic                       busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [LEN_WIDTH:0] UNITS_X =
        (LEN_WIDTH+1)'(UNITS);

    state_t                     state;
    state_t                     state_n;
    logic [OFST_WIDTH-1:0]      src_ofst_q;
    logic [OFST_WIDTH-1:0]      dst_ofst_q;
    logic                       last_q;
    logic [USER_INFO_WIDTH-1:0] user_q;
    logic [LEN_WIDTH-1:0]       rem;
    logic                       first;

    logic [OFST_WIDTH-1:0]      ofst;
    logic [LEN_WIDTH:0]         avail;
    logic [LEN_WIDTH:0]         rem_x;
    logic [LEN_WIDTH:0]         n;
    logic                       beat_done;
    logic                       cmd_hs;
    logic                       rd_hs;
    logic                       cmd_go;

    assign ofst  = first ? src_ofst_q : '0;
    assign avail = UNITS_X -
        {{(LEN_WIDTH+1-OFST_WIDTH){1'b0}}, ofst};
    assign rem_x = {1'b0, rem};
    assign n     = (avail < rem_x) ? avail : rem_x;

    assign beat_done = (rem_x == n);
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign rd_hs     = rd_valid && rd_ready;
    assign cmd_go    = cmd_hs && (cmd_len != '0);
    assign busy      = (state != S_IDLE) || seg_valid;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and handshake readies; flush blocks both sides
    always_comb begin
        state_n   = state;
        cmd_ready = 1'b0;
        rd_ready  = 1'b0;
        if (flush) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid && (cmd_len != '0)) begin
                        state_n = S_RUN;
                    end
                end
                S_RUN: begin
                    rd_ready = !seg_valid || seg_ready;
                    if (rd_ready && rd_valid && beat_done) begin
                        state_n = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Latched command and remaining-unit tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ofst_q <= '0;
            dst_ofst_q <= '0;
            last_q     <= 1'b0;
            user_q     <= '0;
            rem        <= '0;
            first      <= 1'b0;
        end else if (flush) begin
            rem        <= '0;
            first      <= 1'b0;
        end else if (cmd_go) begin
            src_ofst_q <= cmd_src_ofst;
            dst_ofst_q <= cmd_dst_ofst;
            last_q     <= cmd_last;
            user_q     <= cmd_user_info;
            rem        <= cmd_len;
            first      <= 1'b1;
        end else if (rd_hs) begin
            rem        <= rem - n[LEN_WIDTH-1:0];
            first      <= 1'b0;
        end
    end

    // One-entry output buffer; sideband is captured per beat so a
    // newly accepted command cannot disturb a beat still waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_valid          <= 1'b0;
            seg_data           <= '0;
            seg_bgin           <= 1'b0;
            seg_done           <= 1'b0;
            seg_last           <= 1'b0;
            seg_unit_num       <= '0;
            seg_offset         <= '0;
            seg_initial_offset <= '0;
            seg_user_info      <= '0;
        end else if (flush) begin
            seg_valid          <= 1'b0;
        end else if (rd_hs) begin
            seg_valid          <= 1'b1;
            seg_data           <= rd_data;
            seg_bgin           <= first;
            seg_done           <= beat_done;
            seg_last           <= last_q && beat_done;
            seg_unit_num       <= n[PTR_WIDTH-1:0];
            seg_offset         <= ofst;
            seg_initial_offset <= dst_ofst_q;
            seg_user_info      <= user_q;
        end else if (seg_valid && seg_ready) begin
            seg_valid          <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_fifo_seg_gen.sv
// tb_mux_fifo_seg_gen: randomized scoreboard bench for the
// segment generator with a unit-interval reference model.
module tb_mux_fifo_seg_gen;

    localparam int U  = 4;
    localparam int OW = 2;
    localparam int PW = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_src_ofst = '0;
    logic [1:0]  cmd_dst_ofst = '0;
    logic [15:0] cmd_len = '0;
    logic        cmd_last = 1'b0;
    logic [7:0]  cmd_user_info = '0;
    logic [31:0] rd_data = '0;
    logic        rd_valid = 1'b0;
    logic        rd_ready;
    logic [31:0] seg_data;
    logic        seg_valid;
    logic        seg_ready = 1'b0;
    logic        seg_bgin;
    logic        seg_done;
    logic        seg_last;
    logic [2:0]  seg_unit_num;
    logic [1:0]  seg_offset;
    logic [1:0]  seg_initial_offset;
    logic [7:0]  seg_user_info;
    logic        busy;

    always #5 clk = ~clk;

    mux_fifo_seg_gen dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src_ofst(cmd_src_ofst),
        .cmd_dst_ofst(cmd_dst_ofst),
        .cmd_len(cmd_len), .cmd_last(cmd_last),
        .cmd_user_info(cmd_user_info),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .seg_data(seg_data), .seg_valid(seg_valid),
        .seg_ready(seg_ready), .seg_bgin(seg_bgin),
        .seg_done(seg_done), .seg_last(seg_last),
        .seg_unit_num(seg_unit_num),
        .seg_offset(seg_offset),
        .seg_initial_offset(seg_initial_offset),
        .seg_user_info(seg_user_info), .busy(busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  off;
        logic [2:0]  un;
        logic        bgin;
        logic        done;
        logic        last;
        logic [1:0]  init;
        logic [7:0]  user;
    } beat_t;

    beat_t pend[$];
    beat_t exp_q[$];
    int    checks = 0;
    int    fails = 0;
    int    rd_pct = 100;
    int    rdy_pct = 100;
    bit    rdy_man = 1'b0;

    task automatic chk(string nm, logic [63:0] act,
                       logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic fail_now(string nm);
        checks++;
        fails++;
        $display("FAIL %s: event not expected/timed out", nm);
    endtask

    // Beat i covers word units [i*U, i*U+U); the command covers
    // units [ofst, ofst+len) of the source word stream.
    function automatic void gen(int ofst, int len, int dst,
                                int lst, int usr);
        int e, nb, lo, s, t;
        beat_t b;
        if (len == 0) return;
        e  = ofst + len;
        nb = (e + U - 1) / U;
        for (int i = 0; i < nb; i++) begin
            lo = i * U;
            s  = (ofst > lo) ? ofst : lo;
            t  = (e < lo + U) ? e : lo + U;
            b      = '0;
            b.off  = OW'(s - lo);
            b.un   = PW'(t - s);
            b.bgin = (i == 0);
            b.done = (i == nb - 1);
            b.last = (lst != 0) && (i == nb - 1);
            b.init = OW'(dst);
            b.user = 8'(usr);
            pend.push_back(b);
        end
    endfunction

    always @(negedge clk) begin
        beat_t a, b;
        if (rst_n) begin
            if (flush) begin
                pend.delete();
                exp_q.delete();
            end else begin
                if (seg_valid && seg_ready) begin
                    a = {seg_data, seg_offset, seg_unit_num,
                         seg_bgin, seg_done, seg_last,
                         seg_initial_offset, seg_user_info};
                    if (exp_q.size() == 0) begin
                        fail_now("seg_extra");
                    end else begin
                        b = exp_q.pop_front();
                        chk("seg_beat", 64'(a), 64'(b));
                    end
                end
                if (rd_valid && rd_ready) begin
                    if (pend.size() == 0) begin
                        fail_now("rd_extra");
                    end else begin
                        b = pend.pop_front();
                        b.data = rd_data;
                        exp_q.push_back(b);
                    end
                end
                if (cmd_valid && cmd_ready)
                    gen(int'(cmd_src_ofst), int'(cmd_len),
                        int'(cmd_dst_ofst), int'(cmd_last),
                        int'(cmd_user_info));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rd_valid = (int'($urandom_range(99)) < rd_pct);
            rd_data  = $urandom;
            if (!rdy_man)
                seg_ready = (int'($urandom_range(99)) < rdy_pct);
        end
    end

    task automatic send(int ofst, int len, int dst,
                        int lst, int usr);
        int n = 0;
        @(posedge clk);
        #1;
        cmd_valid     = 1'b1;
        cmd_src_ofst  = OW'(ofst);
        cmd_len       = 16'(len);
        cmd_dst_ofst  = OW'(dst);
        cmd_last      = lst[0];
        cmd_user_info = 8'(usr);
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 300);
        if (!cmd_ready) fail_now("cmd_timeout");
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_q.size() != 0 ||
                    pend.size() != 0) && n < 3000);
        if (n >= 3000) fail_now("idle_timeout");
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!seg_valid && n < 100);
        if (!seg_valid) fail_now("valid_timeout");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t snap, cur;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_seg_valid", 64'(seg_valid), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_rd_ready", 64'(rd_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_unit_num", 64'(seg_unit_num), 64'd0);
        chk("rst_user", 64'(seg_user_info), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(1, 6, 2, 1, 8'h5a);
        wait_idle();
        send(0, 4, 1, 0, 8'h33);
        wait_idle();
        send(3, 2, 0, 0, 8'h11);
        send(3, 1, 3, 1, 8'h22);
        wait_idle();

        send(2, 0, 1, 1, 8'h44);
        repeat (4) begin
            @(negedge clk);
            chk("len0_cmd_ready", 64'(cmd_ready), 64'd1);
            chk("len0_rd_ready", 64'(rd_ready), 64'd0);
            chk("len0_seg_valid", 64'(seg_valid), 64'd0);
        end

        rdy_man = 1'b1;
        @(posedge clk);
        #1;
        seg_ready = 1'b0;
        send(0, 12, 2, 1, 8'h77);
        wait_valid();
        snap = {seg_data, seg_offset, seg_unit_num, seg_bgin,
                seg_done, seg_last, seg_initial_offset,
                seg_user_info};
        repeat (3) begin
            @(negedge clk);
            cur = {seg_data, seg_offset, seg_unit_num, seg_bgin,
                   seg_done, seg_last, seg_initial_offset,
                   seg_user_info};
            chk("bp_stable", 64'(cur), 64'(snap));
            chk("bp_rd_ready", 64'(rd_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        seg_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_stream", 64'(seg_valid), 64'd1);
        end
        @(negedge clk);
        chk("bp_drained", 64'(seg_valid), 64'd0);
        rdy_man = 1'b0;
        wait_idle();

        rdy_man = 1'b1;
        @(posedge clk);
        #1;
        seg_ready = 1'b0;
        send(1, 10, 1, 1, 8'h99);
        wait_valid();
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("fl_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("fl_rd_ready", 64'(rd_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("fl_seg_valid", 64'(seg_valid), 64'd0);
        chk("fl_busy", 64'(busy), 64'd0);
        chk("fl_cmd_ready2", 64'(cmd_ready), 64'd1);
        rdy_man = 1'b0;
        send(0, 4, 3, 1, 8'hc3);
        wait_idle();

        rd_pct  = 70;
        rdy_pct = 70;
        for (int k = 0; k < 40; k++) begin
            send(int'($urandom_range(3)),
                 ($urandom_range(7) == 0) ? 0
                     : int'($urandom_range(1, 13)),
                 int'($urandom_range(3)),
                 int'($urandom_range(1)),
                 int'($urandom_range(255)));
        end
        wait_idle();
        chk("drain", 64'(exp_q.size() + pend.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
